ga_generation_sequencer: RTL and testbench

- Top-level controller for one GA run. It sequences the three population stages once per generation, in this order: selection, then mutation, then fitness evaluation.
- Each stage gets a single-cycle start pulse and a fresh 32-bit PRNG seed. The block then waits for that stage's done.
- Per-stage timeouts trap hung stages. The block counts generations and terminates on MAX_GEN, convergence or abort.

---
 rtl/ga_generation_sequencer.sv | 141 ++++++++++++++
 tb/tb_ga_generation_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ga_generation_sequencer.sv
// Generation sequencer for one GA run: drives selection, mutation and fitness stages
// in order, hands each a fresh LFSR seed, traps hung stages and counts generations.
module ga_generation_sequencer #(
  parameter int unsigned MAX_GEN   = 1000,
  parameter int unsigned GEN_W     = 16,
  parameter logic [31:0] SEED_INIT = 32'hACE12015,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             abort,
  output logic             sel_start,
  input  logic             sel_done,
  output logic             mut_start,
  input  logic             mut_done,
  output logic             fit_start,
  input  logic             fit_done,
  input  logic             fit_converged,
  output logic [31:0]      prg_seed,
  output logic [GEN_W-1:0] generation,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0]      SEED_RST  = (SEED_INIT == 32'h0) ? 32'h1 : SEED_INIT;
  localparam logic [GEN_W-1:0] GEN_LAST  = GEN_W'(MAX_GEN);
  localparam logic [8:0]       TMO_LIMIT = 9'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE,
    SEL_START,
    SEL_WAIT,
    MUT_START,
    MUT_WAIT,
    FIT_START,
    FIT_WAIT,
    NEXT_GEN,
    FINISH,
    ERROR
  } state_t;

  state_t           state;
  state_t           wait_exit;
  logic             stage_done;
  logic [7:0]       tmo_cnt;
  logic [8:0]       tmo_inc;
  logic             converged;
  logic [GEN_W-1:0] gen_inc;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  // Each WAIT state listens only to its own stage's done.
  always_comb begin
    stage_done = 1'b0;
    wait_exit  = IDLE;
    case (state)
      SEL_WAIT: begin stage_done = sel_done; wait_exit = MUT_START; end
      MUT_WAIT: begin stage_done = mut_done; wait_exit = FIT_START; end
      FIT_WAIT: begin stage_done = fit_done; wait_exit = NEXT_GEN;  end
      default:  ;
    endcase
  end

  assign tmo_inc = {1'b0, tmo_cnt} + 9'd1;
  assign gen_inc = generation + GEN_W'(1);

  // NOTE: state is updated with non-blocking assignments only, so every branch below
  // sees the pre-edge values of state, prg_seed and generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prg_seed   <= SEED_RST;
      generation <= '0;
      tmo_cnt    <= '0;
      converged  <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (run) begin
            state      <= SEL_START;
            generation <= '0;
            converged  <= 1'b0;
            prg_seed   <= lfsr_next(SEED_RST);
          end
        end
        SEL_START, MUT_START, FIT_START: begin
          tmo_cnt <= '0;
          if (abort)                  state <= IDLE;
          else if (state == SEL_START) state <= SEL_WAIT;
          else if (state == MUT_START) state <= MUT_WAIT;
          else                         state <= FIT_WAIT;
        end
        SEL_WAIT, MUT_WAIT, FIT_WAIT: begin
          // Priority: abort, then the stage's done, then the timeout.
          if (abort) begin
            state <= IDLE;
          end else if (stage_done) begin
            state <= wait_exit;
            if (state == FIT_WAIT) converged <= fit_converged;
            else                   prg_seed  <= lfsr_next(prg_seed);
          end else if (tmo_inc == TMO_LIMIT) begin
            state <= ERROR;
          end else begin
            tmo_cnt <= tmo_inc[7:0];
          end
        end
        NEXT_GEN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            generation <= gen_inc;
            if (gen_inc == GEN_LAST || converged) begin
              state <= FINISH;
            end else begin
              state    <= SEL_START;
              prg_seed <= lfsr_next(prg_seed);
            end
          end
        end
        ERROR: begin
          if (abort) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly, so reset clears them without a clock.
  assign sel_start = (state == SEL_START);
  assign mut_start = (state == MUT_START);
  assign fit_start = (state == FIT_START);
  assign done      = (state == FINISH);
  assign error     = (state == ERROR);
  assign busy      = !(state inside {IDLE, FINISH, ERROR});

endmodule

// File: tb/tb_ga_generation_sequencer.sv
// Directed bench for ga_generation_sequencer: a per-cycle vector table for a full
// three-generation run, then hand sequences for convergence, timeout, abort and reset.
module tb_ga_generation_sequencer;

  localparam logic [31:0] SEED = 32'h00000001;

  logic        clk = 1'b0;
  logic        reset, run, abort;
  logic        sel_done, mut_done, fit_done, fit_converged;
  logic        sel_start, mut_start, fit_start;
  logic [31:0] prg_seed;
  logic [15:0] generation;
  logic        busy, done, error;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] exp_seed;

  ga_generation_sequencer #(
    .MAX_GEN(3), .GEN_W(16), .SEED_INIT(SEED), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .abort(abort),
    .sel_start(sel_start), .sel_done(sel_done),
    .mut_start(mut_start), .mut_done(mut_done),
    .fit_start(fit_start), .fit_done(fit_done), .fit_converged(fit_converged),
    .prg_seed(prg_seed), .generation(generation),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic run, abort, sd, md, fd, fc;
    logic sel, mut, fit, busy, done, err;
    int   gen;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] lfsr_ref(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  function automatic void add(input logic r, a, sd, md, fd, fc,
                              input logic s, m, f, b, d, e, input int g);
    vec_t v;
    v = '{run: r, abort: a, sd: sd, md: md, fd: fd, fc: fc,
          sel: s, mut: m, fit: f, busy: b, done: d, err: e, gen: g};
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs checked there reflect the last rising edge.
  task automatic drive(input logic r, a, sd, md, fd, fc);
    @(negedge clk);
    run = r; abort = a; sel_done = sd; mut_done = md; fit_done = fd; fit_converged = fc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " starts"}, {29'd0, sel_start, mut_start, fit_start}, 32'd0);
    check({tag, " busy"},   {31'd0, busy},  32'd0);
    check({tag, " done"},   {31'd0, done},  32'd0);
    check({tag, " error"},  {31'd0, error}, 32'd0);
    check({tag, " gen"},    {16'd0, generation}, 32'd0);
    check({tag, " seed"},   prg_seed, SEED);
  endtask

  // One stage: START cycle, one quiet WAIT cycle, then a WAIT cycle with done.
  task automatic stage(input int which, input logic conv);
    drive(0, 0, 0, 0, 0, 0);
    exp_seed = lfsr_ref(exp_seed);
    check($sformatf("stage%0d start", which), {29'd0, sel_start, mut_start, fit_start},
          32'(3'b100 >> which));
    check($sformatf("stage%0d seed", which), prg_seed, exp_seed);
    drive(0, 0, 0, 0, 0, 0);
    check($sformatf("stage%0d wait quiet", which), {29'd0, sel_start, mut_start, fit_start}, 32'd0);
    drive(0, 0, which == 0, which == 1, which == 2, conv);
    check($sformatf("stage%0d seed held", which), prg_seed, exp_seed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 0; abort = 0;
    sel_done = 0; mut_done = 0; fit_done = 0; fit_converged = 0;

    // Full run: abort/run while idle or finished, run held while busy ignored.
    add(0,1,0,0,0,0, 0,0,0,0,0,0, 0);
    add(1,0,0,0,0,0, 0,0,0,0,0,0, 0);
    for (int g = 0; g < 3; g++) begin
      add(0,0,0,0,0,0, 1,0,0,1,0,0, g);
      add(0,0,0,0,0,0, 0,0,0,1,0,0, g);
      add(0,0,1,0,0,0, 0,0,0,1,0,0, g);
      add(0,0,0,0,0,0, 0,1,0,1,0,0, g);
      add(0,0,0,0,0,0, 0,0,0,1,0,0, g);
      add(0,0,0,1,0,0, 0,0,0,1,0,0, g);
      add(0,0,0,0,0,0, 0,0,1,1,0,0, g);
      add(0,0,0,0,0,0, 0,0,0,1,0,0, g);
      add(0,0,0,0,1,0, 0,0,0,1,0,0, g);
      add(g == 0,0,0,0,0,0, 0,0,0,1,0,0, g);
    end
    add(0,1,0,0,0,0, 0,0,0,0,1,0, 3);
    add(0,0,0,0,0,0, 0,0,0,0,1,0, 3);

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    exp_seed = SEED;

    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].abort, tbl[i].sd, tbl[i].md, tbl[i].fd, tbl[i].fc);
      if (tbl[i].sel || tbl[i].mut || tbl[i].fit) exp_seed = lfsr_ref(exp_seed);
      check($sformatf("v%0d sel", i),  {31'd0, sel_start}, {31'd0, tbl[i].sel});
      check($sformatf("v%0d mut", i),  {31'd0, mut_start}, {31'd0, tbl[i].mut});
      check($sformatf("v%0d fit", i),  {31'd0, fit_start}, {31'd0, tbl[i].fit});
      check($sformatf("v%0d busy", i), {31'd0, busy},      {31'd0, tbl[i].busy});
      check($sformatf("v%0d done", i), {31'd0, done},      {31'd0, tbl[i].done});
      check($sformatf("v%0d err", i),  {31'd0, error},     {31'd0, tbl[i].err});
      check($sformatf("v%0d gen", i),  {16'd0, generation}, 32'(tbl[i].gen));
      check($sformatf("v%0d seed", i), prg_seed, exp_seed);
      if (i == 2) check("first sel seed", prg_seed, 32'h80200003);
      if (i == 5) check("first mut seed", prg_seed, 32'hC0300002);
    end

    // Convergence on the first fit_done ends the run at generation 1.
    drive(1, 0, 0, 0, 0, 0);
    exp_seed = SEED;
    stage(0, 0); stage(1, 0); stage(2, 1);
    drive(0, 0, 0, 0, 0, 0);
    check("conv next_gen busy", {31'd0, busy}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    check("conv done", {31'd0, done}, 32'd1);
    check("conv gen", {16'd0, generation}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    check("conv no sel", {31'd0, sel_start}, 32'd0);

    // Timeout: mut_done never comes; ERROR five cycles after mut_start.
    drive(1, 0, 0, 0, 0, 0);
    exp_seed = SEED;
    stage(0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("tmo mut_start", {31'd0, mut_start}, 32'd1);
    for (int w = 0; w < 4; w++) drive(0, 0, 0, 0, 0, 0);
    check("tmo last wait err", {31'd0, error}, 32'd0);
    check("tmo last wait busy", {31'd0, busy}, 32'd1);
    drive(0, 1, 0, 0, 0, 0);
    check("tmo error", {31'd0, error}, 32'd1);
    check("tmo busy", {31'd0, busy}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    check("tmo abort err", {31'd0, error}, 32'd0);
    check("tmo abort idle", {30'd0, busy, done}, 32'd0);

    // Abort in FIT_WAIT of generation 1, together with fit_done: abort wins.
    drive(1, 0, 0, 0, 0, 0);
    exp_seed = SEED;
    stage(0, 0); stage(1, 0); stage(2, 0);
    drive(0, 0, 0, 0, 0, 0);
    stage(0, 0); stage(1, 0);
    drive(0, 0, 0, 0, 0, 0);
    exp_seed = lfsr_ref(exp_seed);
    check("abort fit_start", {31'd0, fit_start}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort gen", {16'd0, generation}, 32'd1);
    check("abort seed", prg_seed, exp_seed);
    drive(0, 0, 0, 0, 0, 0);
    check("abort no start", {29'd0, sel_start, mut_start, fit_start}, 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    exp_seed = SEED;

    // New run clears generation; spurious dones ignored; done wins at the timeout count.
    stage(0, 0);
    drive(0, 0, 0, 1, 0, 0);
    exp_seed = lfsr_ref(exp_seed);
    check("rerun gen", {16'd0, generation}, 32'd0);
    check("spur mut_start", {31'd0, mut_start}, 32'd1);
    for (int w = 0; w < 3; w++) begin
      drive(0, 0, 1, 0, 0, 0);
      check($sformatf("spur wait%0d", w), {29'd0, sel_start, mut_start, fit_start}, 32'd0);
      check($sformatf("spur busy%0d", w), {30'd0, busy, error}, 32'd2);
    end
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("boundary fit_start", {31'd0, fit_start}, 32'd1);
    check("boundary no error", {31'd0, error}, 32'd0);

    // Asynchronous reset in FIT_WAIT, sampled before the next rising edge.
    drive(0, 0, 0, 0, 0, 0);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async reset");
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check_reset_outputs("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
